// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM pipeline stage between AGEX and WB.
// Non-memory instructions pass straight into the MEM latch. Loads and stores
// go through a valid/ready data-memory port while the stage stalls upstream.
// Optional build macro MEM_MISALIGN_TRAP_EN: misaligned half/word accesses
// issue no request and retire with mem_trap=1 instead.
module mem_access_stage #(
  parameter int DBITS     = 32,
  parameter int REGNOBITS = 5,
  parameter int CNTBITS   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 agex_valid,
  input  logic                 agex_is_load,
  input  logic                 agex_is_store,
  input  logic [1:0]           agex_size,
  input  logic                 agex_unsigned,
  input  logic [DBITS-1:0]     agex_aluout,
  input  logic [DBITS-1:0]     agex_st_data,
  input  logic                 agex_wr_reg,
  input  logic [REGNOBITS-1:0] agex_wregno,
  input  logic [DBITS-1:0]     agex_inst_count,
  output logic                 mem_stall,
  output logic                 dmem_req_valid,
  input  logic                 dmem_req_ready,
  output logic                 dmem_we,
  output logic [DBITS-1:0]     dmem_addr,
  output logic [DBITS-1:0]     dmem_wdata,
  output logic [3:0]           dmem_wstrb,
  input  logic                 dmem_resp_valid,
  input  logic [DBITS-1:0]     dmem_rdata,
  output logic                 mem_valid,
  output logic                 mem_wr_reg,
  output logic [REGNOBITS-1:0] mem_wregno,
  output logic [DBITS-1:0]     mem_wdata,
  output logic [DBITS-1:0]     mem_inst_count,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic                 mem_trap,
`endif
  output logic [CNTBITS-1:0]   stall_cycles
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

  state_t state, state_n;

  // Replicate store data into every lane the strobes may select.
  function automatic logic [DBITS-1:0] fmt_store(input logic [DBITS-1:0] st,
                                                 input logic [1:0] size);
    case (size)
      2'd0:    return {4{st[7:0]}};
      2'd1:    return {2{st[15:0]}};
      default: return st;
    endcase
  endfunction

  // Byte strobes; size 3 behaves as a full word.
  function automatic logic [3:0] fmt_strb(input logic [1:0] a,
                                          input logic [1:0] size);
    case (size)
      2'd0:    return 4'b0001 << a;
      2'd1:    return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Pick the addressed lane out of the read word and sign/zero extend it.
  function automatic logic [DBITS-1:0] load_extract(input logic [DBITS-1:0] rd,
                                                    input logic [1:0] a,
                                                    input logic [1:0] size,
                                                    input logic uns);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = rd[{a, 3'b000} +: 8];
    h = a[1] ? rd[31:16] : rd[15:0];
    case (size)
      2'd0:    return uns ? {{(DBITS-8){1'b0}}, b}  : {{(DBITS-8){b[7]}}, b};
      2'd1:    return uns ? {{(DBITS-16){1'b0}}, h} : {{(DBITS-16){h[15]}}, h};
      default: return rd;
    endcase
  endfunction

  logic is_mem_op;
  logic start_access;
  assign is_mem_op = agex_is_load | agex_is_store;

`ifdef MEM_MISALIGN_TRAP_EN
  logic misalign;
  logic lat_trap_n;
  assign misalign = is_mem_op &&
                    ((agex_size == 2'd1 && agex_aluout[0]) ||
                     (agex_size[1] && agex_aluout[1:0] != 2'b00));
  assign start_access = (state == S_IDLE) && agex_valid && is_mem_op && !misalign;
`else
  assign start_access = (state == S_IDLE) && agex_valid && is_mem_op;
`endif

  // Hold register for the outstanding access (stage p1)
  logic [DBITS-1:0]     addr_p1;
  logic [1:0]           size_p1;
  logic                 uns_p1;
  logic                 is_store_p1;
  logic                 wr_reg_p1;
  logic [REGNOBITS-1:0] wregno_p1;
  logic [DBITS-1:0]     cnt_p1;
  logic [DBITS-1:0]     st_wdata_p1;
  logic [3:0]           st_wstrb_p1;

  // Capture the memory instruction when the access starts; data only, no reset.
  always_ff @(posedge clk) begin
    if (start_access) begin
      addr_p1     <= agex_aluout;
      size_p1     <= agex_size;
      uns_p1      <= agex_unsigned;
      is_store_p1 <= agex_is_store;
      wr_reg_p1   <= agex_wr_reg;
      wregno_p1   <= agex_wregno;
      cnt_p1      <= agex_inst_count;
      st_wdata_p1 <= fmt_store(agex_st_data, agex_size);
      st_wstrb_p1 <= fmt_strb(agex_aluout[1:0], agex_size);
    end
  end

  assign mem_stall      = (state != S_IDLE) || start_access;
  assign dmem_req_valid = (state == S_REQ);
  assign dmem_we        = is_store_p1;
  assign dmem_addr      = {addr_p1[DBITS-1:2], 2'b00};
  assign dmem_wdata     = st_wdata_p1;
  assign dmem_wstrb     = st_wstrb_p1;

  logic                 lat_we;
  logic                 lat_wr_reg_n;
  logic [REGNOBITS-1:0] lat_wregno_n;
  logic [DBITS-1:0]     lat_wdata_n;
  logic [DBITS-1:0]     lat_cnt_n;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_n;
  end

  // Next state and MEM latch write selection
  always_comb begin
    state_n      = state;
    lat_we       = 1'b0;
    lat_wr_reg_n = 1'b0;
    lat_wregno_n = agex_wregno;
    lat_wdata_n  = agex_aluout;
    lat_cnt_n    = agex_inst_count;
`ifdef MEM_MISALIGN_TRAP_EN
    lat_trap_n   = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (agex_valid && !is_mem_op) begin
          lat_we       = 1'b1;
          lat_wr_reg_n = agex_wr_reg;
        end else if (start_access) begin
          state_n = S_REQ;
        end
`ifdef MEM_MISALIGN_TRAP_EN
        else if (agex_valid && misalign) begin
          lat_we     = 1'b1;
          lat_trap_n = 1'b1;
        end
`endif
      end
      S_REQ: begin
        if (dmem_req_ready) begin
          if (is_store_p1) begin
            state_n      = S_IDLE;
            lat_we       = 1'b1;
            lat_wregno_n = wregno_p1;
            lat_wdata_n  = '0;
            lat_cnt_n    = cnt_p1;
          end else begin
            state_n = S_RESP;
          end
        end
      end
      S_RESP: begin
        if (dmem_resp_valid) begin
          state_n      = S_IDLE;
          lat_we       = 1'b1;
          lat_wr_reg_n = wr_reg_p1;
          lat_wregno_n = wregno_p1;
          lat_wdata_n  = load_extract(dmem_rdata, addr_p1[1:0], size_p1, uns_p1);
          lat_cnt_n    = cnt_p1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // MEM latch (stage p2): payload held while valid is low
  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_valid      <= 1'b0;
      mem_wr_reg     <= 1'b0;
      mem_wregno     <= '0;
      mem_wdata      <= '0;
      mem_inst_count <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
      mem_trap       <= 1'b0;
`endif
    end else begin
      mem_valid <= lat_we;
`ifdef MEM_MISALIGN_TRAP_EN
      mem_trap  <= lat_trap_n;
`endif
      if (lat_we) begin
        mem_wr_reg     <= lat_wr_reg_n;
        mem_wregno     <= lat_wregno_n;
        mem_wdata      <= lat_wdata_n;
        mem_inst_count <= lat_cnt_n;
      end
    end
  end

  // Saturating stall-cycle counter
  always_ff @(posedge clk) begin
    if (!reset)                              stall_cycles <= '0;
    else if (mem_stall && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM stage, directly downstream of AGEX. Consumes the registered AGEX outputs (ALU result or address, store data, writeback control) and performs loads and stores over a valid/ready data-memory port.
- Stalls upstream while an access is outstanding. Drives the MEM latch consumed by WB.
- Exposes the MEM latch contents back to AGEX/DE for forwarding.

Parameters:
- DBITS, 32, data/address width.
- REGNOBITS, 5, register-number width.
- CNTBITS, 32, width of the stall-cycle performance counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset; 0 at a rising clk edge clears all state.
- agex_valid  in  1  AGEX latch holds a valid instruction.
- agex_is_load  in  1  instruction is a load.
- agex_is_store  in  1  instruction is a store.
- agex_size  in  2  access size: 0=byte, 1=half, 2=word.
- agex_unsigned  in  1  zero-extend the load result (LBU/LHU).
- agex_aluout  in  DBITS  ALU result, or effective address for memory ops.
- agex_st_data  in  DBITS  store data (rs2 value).
- agex_wr_reg  in  1  instruction writes a register.
- agex_wregno  in  REGNOBITS  destination register.
- agex_inst_count  in  DBITS  instruction sequence number.
- mem_stall  out  1  upstream must hold the AGEX latch and FE/DE.
- dmem_req_valid  out  1  memory request valid.
- dmem_req_ready  in  1  memory accepts the request.
- dmem_we  out  1  request is a write.
- dmem_addr  out  DBITS  word-aligned address (agex_aluout with [1:0] forced to 0).
- dmem_wdata  out  DBITS  store data replicated per lane.
- dmem_wstrb  out  4  byte write strobes.
- dmem_resp_valid  in  1  read data valid.
- dmem_rdata  in  DBITS  read word.
- mem_valid  out  1  MEM latch valid.
- mem_wr_reg  out  1  latched write enable.
- mem_wregno  out  REGNOBITS  latched destination register.
- mem_wdata  out  DBITS  latched writeback value.
- mem_inst_count  out  DBITS  latched sequence number.
- stall_cycles  out  CNTBITS  saturating count of cycles with mem_stall=1.
- mem_trap  out  1  misaligned access; present only with MEM_MISALIGN_TRAP_EN.

Behaviour:
- Reset (reset=0 at an edge):
  - state=IDLE; all latch outputs, mem_trap and stall_cycles = 0.
  - dmem_req_valid=0 from the next cycle.
  - An in-flight request is abandoned. Any later dmem_resp_valid is ignored because the FSM is in IDLE.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - agex_valid and neither load nor store: MEM latch ← {1, wr_reg, wregno, aluout, inst_count} at the next edge. Latency 1, no stall.
  - agex_valid and (load or store): capture address, size, unsigned flag, wregno, wr_reg, inst_count and formatted store data into a hold register; go to REQ. Latch valid=0 next cycle (bubble).
  - agex_valid=0: latch valid ← 0.
- REQ:
  - dmem_req_valid=1; dmem_we, addr, wdata and wstrb come from the hold register and are stable until accepted.
  - On req_ready=1, a store writes the latch {1, 0, wregno, 0, inst_count} and goes to IDLE.
  - On req_ready=1, a load goes to RESP.
- RESP:
  - dmem_req_valid=0.
  - On resp_valid=1: extract the lane selected by addr[1:0] and size, sign- or zero-extend it, write the latch {1, wr_reg, wregno, data, inst_count}, and go to IDLE.
  - resp_valid arriving in IDLE or REQ is ignored.
- mem_stall:
  - = (state!=IDLE) or (state==IDLE and agex_valid and mem op), i.e. combinational, asserted in the capture cycle.
  - Deasserts in the cycle after completion, so the next AGEX instruction is accepted then.
  - Minimum load latency: 3 cycles (capture, REQ with ready=1, RESP with resp_valid=1).
- Store formatting:
  - byte: wdata={4{st[7:0]}}, wstrb=1<<addr[1:0].
  - half: wdata={2{st[15:0]}}, wstrb=addr[1]?4'b1100:4'b0011.
  - word: wdata=st, wstrb=4'b1111.
- Latch outputs hold their values while valid=0; consumers must gate on mem_valid.
- stall_cycles increments each cycle mem_stall=1 and saturates at all-ones.
- size=3 is treated as word.

Optional Feature:
- MEM_MISALIGN_TRAP_EN defined:
  - half with addr[0]=1, or word with addr[1:0]≠0, issues no request and goes IDLE→IDLE.
  - Latch written {1, 0, wregno, agex_aluout, inst_count} with mem_trap=1 for one latch cycle.
  - mem_stall is 0 for that instruction.
- Not defined: no mem_trap port. Misaligned accesses use the aligned word address, with lanes selected as above (half with addr[0]=1 uses the addr[1] half).

Test Plan:
- ALU op: agex_valid=1, aluout=0x0000_0042, wregno=5, wr_reg=1 -> next cycle mem_valid=1, wdata=0x42, wregno=5, mem_stall=0.
- Signed byte load: addr=0x1003, rdata=0x80FF_0000, ready=1 immediately, resp one cycle later -> dmem_addr=0x1000, dmem_we=0; mem_wdata=0xFFFF_FF80 three cycles after capture; mem_stall high for exactly 3 cycles.
- Half store: addr=0x2002, st_data=0x1234_ABCD, ready held 0 for 4 cycles -> dmem_wdata=0xABCD_ABCD, wstrb=4'b1100, stable across the wait; stall_cycles=6 at completion.
- LHU: addr=0x3000, rdata=0x0000_F00D -> mem_wdata=0x0000_F00D. Same access signed -> 0xFFFF_F00D.
- Reset mid-load: reset=0 in RESP, then resp_valid=1 one cycle after release -> mem_valid stays 0, state IDLE, stall_cycles=0.
- With MEM_MISALIGN_TRAP_EN, word load at 0x1001 -> no dmem_req_valid; next cycle mem_valid=1, mem_trap=1, mem_wr_reg=0.
